fft_butterfly_stage: RTL and testbench

- Radix-2 DIF butterfly, one complex pair per cycle. Sits directly downstream of the FFT input-folding stage.
- Consumes the aligned pair: x[n] on in_0, x[n+N/2] on in_1, plus the folding stage's valid.
- Produces y0 = x[n] + x[n+N/2] and y1 = (x[n] − x[n+N/2])·W_N^k, with k tracked internally; both feed the next stage.

---
 rtl/fft_butterfly_stage.sv | 123 ++++++++++++
 tb/tb_fft_butterfly_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_stage.sv
// fft_butterfly_stage: radix-2 DIF butterfly, out_0 = a+b, out_1 = (a-b)*W_N^k, three register stages.
// Complex ports are packed {re, im}, each component DATA_W-bit signed.
module fft_butterfly_stage #(
    parameter int   N      = 8,
    parameter int   DATA_W = 16,
    parameter int   TW_W   = 16,
    parameter logic SCALE  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [2*DATA_W-1:0] in_0,
    input  logic [2*DATA_W-1:0] in_1,
    output logic [2*DATA_W-1:0] out_0,
    output logic [2*DATA_W-1:0] out_1,
    output logic                out_valid,
    output logic                out_first
);
    localparam int KW = $clog2(N / 2);
    localparam int DW = DATA_W + 1;
    localparam int PW = DW + TW_W;
    localparam int RW = PW + 1;
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (TW_W - 2);

    function automatic logic signed [TW_W-1:0] tw(input int k, input logic imag);
        real v;
        v = (imag ? -$sin(2.0 * PI * k / N) : $cos(2.0 * PI * k / N)) * (2.0 ** (TW_W - 1) - 1.0);
        return TW_W'($rtoi(v + (v >= 0.0 ? 0.5 : -0.5)));
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [RW-1:0] x);
        return (&x[RW-1:DATA_W-1] || !(|x[RW-1:DATA_W-1])) ? x[DATA_W-1:0]
                                                          : {x[RW-1], {(DATA_W-1){~x[RW-1]}}};
    endfunction

    logic signed [TW_W-1:0] wr_tab [N/2];
    logic signed [TW_W-1:0] wi_tab [N/2];
    for (genvar i = 0; i < N / 2; i++) begin : g_tw
        localparam logic signed [TW_W-1:0] WR = tw(i, 1'b0);
        localparam logic signed [TW_W-1:0] WI = tw(i, 1'b1);
        assign wr_tab[i] = WR;
        assign wi_tab[i] = WI;
    end

    logic signed [DATA_W-1:0] ar, ai, br, bi;
    logic signed [DW-1:0]     sr, si, dr, di;
    logic signed [DATA_W-1:0] s_re, s_im;
    logic signed [DW-1:0]     d_re, d_im;
    assign {ar, ai} = in_0;
    assign {br, bi} = in_1;
    assign sr = DW'(ar) + DW'(br);
    assign si = DW'(ai) + DW'(bi);
    assign dr = DW'(ar) - DW'(br);
    assign di = DW'(ai) - DW'(bi);

    // Full-scale mode keeps the difference one bit wider so the twiddle stage sees it unclipped.
    always_comb begin
        s_re = SCALE ? DATA_W'(sr >>> 1) : sat(RW'(sr));
        s_im = SCALE ? DATA_W'(si >>> 1) : sat(RW'(si));
        d_re = SCALE ? (dr >>> 1) : dr;
        d_im = SCALE ? (di >>> 1) : di;
    end

    logic [KW-1:0]            k, k1, k2;
    logic                     v1, v2;
    logic signed [DATA_W-1:0] s1_re, s1_im, s2_re, s2_im;
    logic signed [DW-1:0]     s1_dr, s1_di;
    logic signed [TW_W-1:0]   wr, wi;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [RW-1:0]     re, im, re_r, im_r;
    assign wr = wr_tab[k1];
    assign wi = wi_tab[k1];
    assign re = RW'(p_rr) - RW'(p_ii);
    assign im = RW'(p_ri) + RW'(p_ir);
    assign re_r = (re + HALF) >>> (TW_W - 1);
    assign im_r = (im + HALF) >>> (TW_W - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            k <= '0;
            k1 <= '0;
            k2 <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            s1_re <= '0;
            s1_im <= '0;
            s1_dr <= '0;
            s1_di <= '0;
            s2_re <= '0;
            s2_im <= '0;
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
            out_0 <= '0;
            out_1 <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
        end else if (enable) begin
            if (in_valid) k <= k + KW'(1);
            v1 <= in_valid;
            k1 <= k;
            s1_re <= s_re;
            s1_im <= s_im;
            s1_dr <= d_re;
            s1_di <= d_im;
            v2 <= v1;
            k2 <= k1;
            s2_re <= s1_re;
            s2_im <= s1_im;
            p_rr <= PW'(s1_dr) * PW'(wr);
            p_ii <= PW'(s1_di) * PW'(wi);
            p_ri <= PW'(s1_dr) * PW'(wi);
            p_ir <= PW'(s1_di) * PW'(wr);
            out_valid <= v2;
            out_first <= v2 && (k2 == '0);
            out_0 <= {s2_re, s2_im};
            out_1 <= {sat(re_r), sat(im_r)};
        end
    end
endmodule

// File: tb/tb_fft_butterfly_stage.sv
// tb_fft_butterfly_stage: directed and random vectors into SCALE=0 and SCALE=1 instances,
// checked every cycle against an arithmetic butterfly model plus hand-computed literals.
module tb_fft_butterfly_stage;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_0 = '0;
    logic [31:0] in_1 = '0;
    logic [31:0] o0_a, o1_a, o0_b, o1_b;
    logic        ov_a, of_a, ov_b, of_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fft_butterfly_stage #(.N(N), .DATA_W(16), .TW_W(16), .SCALE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_0(in_0), .in_1(in_1), .out_0(o0_a), .out_1(o1_a),
        .out_valid(ov_a), .out_first(of_a)
    );

    fft_butterfly_stage #(.N(N), .DATA_W(16), .TW_W(16), .SCALE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_0(in_0), .in_1(in_1), .out_0(o0_b), .out_1(o1_b),
        .out_valid(ov_b), .out_first(of_b)
    );

    typedef struct {
        int          due;
        logic [31:0] e0a, e1a, e0b, e1b;
        logic        first;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   en_cnt = 0;
    int   km = 0;
    logic started = 1'b0;
    logic ev;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint satl(longint x);
        return x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
    endfunction

    function automatic longint twid(int k, logic imag);
        real v;
        v = imag ? -$sin(2.0 * 3.14159265358979 * k / N) : $cos(2.0 * 3.14159265358979 * k / N);
        v = v * 32767.0;
        return longint'($rtoi(v + (v >= 0.0 ? 0.5 : -0.5)));
    endfunction

    function automatic logic [31:0] cplx(longint re, longint im);
        return {re[15:0], im[15:0]};
    endfunction

    // Butterfly in plain integer arithmetic: y0 = a+b, y1 = round((a-b)*W) with saturation.
    function automatic void butterfly(input logic [31:0] a, input logic [31:0] b, input int k,
                                      input logic scale, output logic [31:0] y0, output logic [31:0] y1);
        longint ar, ai, br, bi, sr, si, dr, di, wr, wi;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        sr = ar + br;
        si = ai + bi;
        dr = ar - br;
        di = ai - bi;
        wr = twid(k, 1'b0);
        wi = twid(k, 1'b1);
        if (scale) begin
            sr = sr >>> 1;
            si = si >>> 1;
            dr = dr >>> 1;
            di = di >>> 1;
        end else begin
            sr = satl(sr);
            si = satl(si);
        end
        y0 = cplx(sr, si);
        y1 = cplx(satl((dr * wr - di * wi + 16384) >>> 15), satl((dr * wi + di * wr + 16384) >>> 15));
    endfunction

    // Model: every accepted pair is due two enabled edges after the edge that accepts it.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            q.delete();
            km = 0;
            started = 1'b1;
        end else if (enable) begin
            en_cnt++;
            if (in_valid) begin
                e.due = en_cnt + 2;
                butterfly(in_0, in_1, km, 1'b0, e.e0a, e.e1a);
                butterfly(in_0, in_1, km, 1'b1, e.e0b, e.e1b);
                e.first = (km == 0);
                q.push_back(e);
                km = (km + 1) % (N / 2);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            while (q.size() > 0 && q[0].due < en_cnt) void'(q.pop_front());
            ev = q.size() > 0 && q[0].due == en_cnt;
            chk1("valid_s0", ov_a, ev);
            chk1("valid_s1", ov_b, ev);
            chk1("known", $isunknown({o0_a, o1_a, o0_b, o1_b, ov_a, ov_b, of_a, of_b}), 1'b0);
            if (ev) begin
                chk32("out0_s0", o0_a, q[0].e0a);
                chk32("out1_s0", o1_a, q[0].e1a);
                chk32("out0_s1", o0_b, q[0].e0b);
                chk32("out1_s1", o1_b, q[0].e1b);
                chk1("first_s0", of_a, q[0].first);
                chk1("first_s1", of_b, q[0].first);
            end else begin
                chk1("first_idle_s0", of_a, 1'b0);
                chk1("first_idle_s1", of_b, 1'b0);
            end
        end
    end

    task automatic drive(logic r, logic en, logic iv, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        reset = r;
        enable = en;
        in_valid = iv;
        in_0 = a;
        in_1 = b;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (2) drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk32("reset_out0", o0_a, '0);
        chk32("reset_out1", o1_a, '0);
        chk1("reset_valid", ov_a, 1'b0);
        chk1("reset_first", of_a, 1'b0);

        a = cplx(3000, 0);
        b = cplx(1000, 0);
        repeat (3) drive(1'b1, 1'b1, 1'b1, a, b);
        chk1("latency_before", ov_a, 1'b0);
        drive(1'b1, 1'b1, 1'b1, a, b);
        chk1("latency_at3", ov_a, 1'b1);
        chk32("basic_out0_k0", o0_a, cplx(4000, 0));
        chk32("basic_out1_k0", o1_a, cplx(2000, 0));
        chk1("basic_first_k0", of_a, 1'b1);
        idle(1);
        chk1("basic_first_k1", of_a, 1'b0);
        chk32("basic_out0_k1", o0_a, cplx(4000, 0));
        idle(1);
        chk32("basic_out1_k2", o1_a, cplx(0, -2000));
        idle(2);

        drive(1'b1, 1'b1, 1'b1, cplx(32767, 0), cplx(-32768, 0));
        drive(1'b1, 1'b1, 1'b1, cplx(32767, -32768), cplx(32767, -32768));
        drive(1'b1, 1'b1, 1'b1, cplx(32767, 32767), cplx(32767, 32767));
        drive(1'b1, 1'b1, 1'b1, cplx(-1234, 567), cplx(890, -4321));
        chk32("sat_diff_k0", o1_a, cplx(32767, 0));
        idle(1);
        chk32("sat_sum", o0_a, cplx(32767, -32768));
        idle(1);
        chk32("scale_out0", o0_b, cplx(32767, 32767));
        chk32("scale_out1", o1_b, '0);
        idle(2);

        drive(1'b1, 1'b1, 1'b1, cplx(100, 200), cplx(-300, 400));
        drive(1'b1, 1'b1, 1'b1, cplx(500, -600), cplx(700, 800));
        repeat (5) drive(1'b1, 1'b0, 1'b1, cplx(9999, 9999), cplx(1, 1));
        drive(1'b1, 1'b1, 1'b1, cplx(-900, 1000), cplx(1100, -1200));
        chk1("stall_hold", ov_a, 1'b0);
        drive(1'b1, 1'b1, 1'b1, cplx(1300, 1400), cplx(-1500, -1600));
        chk1("stall_latency", ov_a, 1'b1);
        chk1("stall_first", of_a, 1'b1);
        idle(3);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, cplx(3000, 0), cplx(1000, 0));
            drive(1'b1, 1'b1, 1'b0, cplx(-5, -5), cplx(7, 7));
        end
        chk32("gap_out1_k2", o1_a, cplx(0, -2000));
        idle(3);

        drive(1'b1, 1'b1, 1'b1, cplx(11, 22), cplx(33, 44));
        drive(1'b1, 1'b1, 1'b1, cplx(55, 66), cplx(77, 88));
        drive(1'b0, 1'b1, 1'b1, cplx(1, 2), cplx(3, 4));
        drive(1'b1, 1'b1, 1'b1, cplx(3000, 0), cplx(1000, 0));
        chk1("midreset_valid", ov_a, 1'b0);
        idle(3);
        chk1("midreset_first", of_a, 1'b1);
        chk32("midreset_out1", o1_a, cplx(2000, 0));
        idle(2);

        repeat (12) drive(1'b1, 1'b1, 1'b1, $urandom, $urandom);
        idle(4);

        repeat (300) drive(($urandom_range(59) != 0), ($urandom_range(3) != 0),
                           ($urandom_range(2) != 0), $urandom, $urandom);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
